// File: rtl/switch_allocator.sv
// Switch allocator for one 3D mesh router.
//
// For every physical output, a round-robin arbiter picks one head-of-line head flit. The
// output then stays locked to that input for the whole wormhole packet. Credit counters
// block an output whose downstream buffer is full. Flits addressed to DROP (port code 7)
// are popped at once and take no output or credit.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[i]      input i has a flit at head of line
//   req_port[i]       requested output of that flit (0..6 physical, 7 = DROP)
//   req_head/req_tail head / tail markers; head=tail=1 marks a single-flit packet
//   grant[i]          flit of input i leaves this cycle (input-buffer pop)
//   out_valid[o]      output o carries a flit this cycle
//   xbar_sel[o]       input driving output o, 0 when idle
//   credit_in[o]      downstream of output o freed one slot
//   credit_err        sticky: a credit came back while the counter was already full
//   drop_count        (only with SWALLOC_DROP_CNT_EN) saturating count of dropped flits
//
// Optional feature macro: SWALLOC_DROP_CNT_EN.
module switch_allocator #(
  parameter int unsigned NUM_PORTS = 7,
  parameter int unsigned CREDITS   = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_PORTS-1:0]                        req_valid,
  input  logic [NUM_PORTS-1:0][2:0]                   req_port,
  input  logic [NUM_PORTS-1:0]                        req_head,
  input  logic [NUM_PORTS-1:0]                        req_tail,
  output logic [NUM_PORTS-1:0]                        grant,
  output logic [NUM_PORTS-1:0]                        out_valid,
  output logic [NUM_PORTS-1:0][$clog2(NUM_PORTS)-1:0] xbar_sel,
  input  logic [NUM_PORTS-1:0]                        credit_in,
  output logic                                        credit_err
`ifdef SWALLOC_DROP_CNT_EN
  ,
  output logic [15:0]                                 drop_count
`endif
);

  localparam int unsigned SelW = $clog2(NUM_PORTS);
  localparam int unsigned CntW = $clog2(CREDITS + 1);
  localparam logic [2:0]      DropPort  = 3'd7;
  localparam logic [CntW-1:0] CreditMax = CntW'(CREDITS);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q  [NUM_PORTS];
  state_e          state_d  [NUM_PORTS];
  logic [SelW-1:0] owner_q  [NUM_PORTS];
  logic [SelW-1:0] owner_d  [NUM_PORTS];
  logic [SelW-1:0] rr_q     [NUM_PORTS];
  logic [SelW-1:0] rr_d     [NUM_PORTS];
  logic [CntW-1:0] credit_q [NUM_PORTS];
  logic [CntW-1:0] credit_d [NUM_PORTS];
  logic            credit_err_q, credit_err_d;

  logic [NUM_PORTS-1:0] ov;        // output o wins an input this cycle
  logic [SelW-1:0]      win [NUM_PORTS];
  logic [NUM_PORTS-1:0] drop_hit;
  logic [NUM_PORTS-1:0] gnt;

  // Arbitration
  always_comb begin
    int unsigned idx;
    idx      = 0;
    ov       = '0;
    gnt      = '0;
    drop_hit = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      win[o] = '0;
      if (credit_q[o] != '0) begin
        if (state_q[o] == StBusy) begin
          if (req_valid[owner_q[o]] && (req_port[owner_q[o]] == 3'(o))) begin
            ov[o]  = 1'b1;
            win[o] = owner_q[o];
          end
        end else begin
          // Scan from farthest to nearest so the candidate closest to rr_ptr is written last.
          for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(rr_q[o]) + k) % NUM_PORTS;
            if (req_valid[idx] && req_head[idx] && (req_port[idx] == 3'(o))) begin
              ov[o]  = 1'b1;
              win[o] = SelW'(idx);
            end
          end
        end
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (ov[o]) gnt[win[o]] = 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      drop_hit[i] = req_valid[i] && (req_port[i] == DropPort);
      if (drop_hit[i]) gnt[i] = 1'b1;
    end
  end

  // Next state
  always_comb begin
    credit_err_d = credit_err_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_d[o]     = rr_q[o];
      credit_d[o] = credit_q[o];
      if (ov[o]) begin
        owner_d[o] = win[o];
        if (state_q[o] == StIdle) rr_d[o] = SelW'((int'(win[o]) + 1) % NUM_PORTS);
        state_d[o] = req_tail[win[o]] ? StIdle : StBusy;
      end
      case ({ov[o], credit_in[o]})
        2'b10: credit_d[o] = credit_q[o] - CntW'(1);
        2'b01: begin
          if (credit_q[o] == CreditMax) credit_err_d = 1'b1;
          else                          credit_d[o]  = credit_q[o] + CntW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]  <= StIdle;
        owner_q[o]  <= '0;
        rr_q[o]     <= '0;
        credit_q[o] <= CreditMax;
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        rr_q[o]     <= rr_d[o];
        credit_q[o] <= credit_d[o];
      end
      credit_err_q <= credit_err_d;
    end
  end

  // Combinational outputs are held at zero throughout reset.
  always_comb begin
    grant     = rst_n ? gnt : '0;
    out_valid = rst_n ? ov  : '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      xbar_sel[o] = (rst_n && ov[o]) ? win[o] : '0;
    end
  end

  assign credit_err = credit_err_q;

`ifdef SWALLOC_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (drop_hit[i]) drop_sum = drop_sum + 17'd1;
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;
  localparam int N  = 7;
  localparam int CR = 4;
  localparam int DROP = 7;

  logic               clk, rst_n;
  logic [N-1:0]       req_valid, req_head, req_tail, credit_in;
  logic [N-1:0][2:0]  req_port;
  logic [N-1:0]       grant, out_valid;
  logic [N-1:0][2:0]  xbar_sel;
  logic               credit_err;
`ifdef SWALLOC_DROP_CNT_EN
  logic [15:0]        drop_count;
`endif

  int vectors, miscompares;

  // Reference model state (spec-level view of each output)
  int m_busy [N];
  int m_owner[N];
  int m_rr   [N];
  int m_credit[N];
  bit m_err;
  int m_drops;
  logic [N-1:0]      exp_grant, exp_ov;
  logic [N-1:0][2:0] exp_sel;

  switch_allocator #(.NUM_PORTS(N), .CREDITS(CR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_port   (req_port),
    .req_head   (req_head),
    .req_tail   (req_tail),
    .grant      (grant),
    .out_valid  (out_valid),
    .xbar_sel   (xbar_sel),
    .credit_in  (credit_in),
    .credit_err (credit_err)
`ifdef SWALLOC_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_in();
    req_valid = '0; req_head = '0; req_tail = '0; req_port = '0; credit_in = '0;
  endtask

  task automatic set_req(input int i, input int port, input bit head, input bit tail);
    req_valid[i] = 1'b1; req_port[i] = 3'(port); req_head[i] = head; req_tail[i] = tail;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_busy[o] = 0; m_owner[o] = 0; m_rr[o] = 0; m_credit[o] = CR;
    end
    m_err = 0; m_drops = 0;
  endtask

  // Winner in IDLE = candidate with the smallest cyclic distance from rr_ptr.
  task automatic model_expect();
    exp_grant = '0; exp_ov = '0; exp_sel = '0;
    for (int o = 0; o < N; o++) begin
      if (m_credit[o] > 0) begin
        if (m_busy[o] != 0) begin
          if (req_valid[m_owner[o]] && int'(req_port[m_owner[o]]) == o) begin
            exp_ov[o] = 1'b1; exp_sel[o] = 3'(m_owner[o]);
          end
        end else begin
          int best_d;
          best_d = N;
          for (int i = 0; i < N; i++) begin
            int d;
            d = (i - m_rr[o] + N) % N;
            if (req_valid[i] && req_head[i] && int'(req_port[i]) == o && d < best_d) begin
              best_d = d; exp_ov[o] = 1'b1; exp_sel[o] = 3'(i);
            end
          end
        end
      end
      if (exp_ov[o]) exp_grant[exp_sel[o]] = 1'b1;
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && int'(req_port[i]) == DROP) exp_grant[i] = 1'b1;
  endtask

  task automatic model_update();
    for (int o = 0; o < N; o++) begin
      if (exp_ov[o] && !credit_in[o]) m_credit[o]--;
      else if (!exp_ov[o] && credit_in[o]) begin
        if (m_credit[o] == CR) m_err = 1; else m_credit[o]++;
      end
      if (exp_ov[o]) begin
        int w;
        w = int'(exp_sel[o]);
        if (m_busy[o] == 0) m_rr[o] = (w + 1) % N;
        m_owner[o] = w;
        m_busy[o]  = req_tail[w] ? 0 : 1;
      end
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && int'(req_port[i]) == DROP) m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_in();
    for (int i = 0; i < N; i++) set_req(i, 1, 1, 1);
    credit_in = '1;
    #1;
    vectors++; if (grant !== '0) begin miscompares++; $display("FAIL reset_grant: got %b want 0", grant); end
    vectors++; if (out_valid !== '0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (xbar_sel !== '0) begin miscompares++; $display("FAIL reset_xbar_sel: got %h want 0", xbar_sel); end
    vectors++; if (credit_err !== 1'b0) begin miscompares++; $display("FAIL reset_credit_err: got %b want 0", credit_err); end
    next_cycle();
    vectors++; if (grant !== '0) begin miscompares++; $display("FAIL reset_hold_grant: got %b want 0", grant); end
    rst_n = 1'b1;
    credit_in = '0;
    @(negedge clk);
    // rr_ptr=0 after reset: input 0 wins among all seven
    vectors++; if (grant !== 7'b0000001) begin miscompares++; $display("FAIL reset_rr_start: got %b want 0000001", grant); end
    vectors++; if (xbar_sel[1] !== 3'd0) begin miscompares++; $display("FAIL reset_rr_sel: got %0d want 0", xbar_sel[1]); end
    vectors++; if (credit_err !== 1'b0) begin miscompares++; $display("FAIL reset_no_err: got %b want 0", credit_err); end
    next_cycle();
    clr_in();
  endtask

  task automatic test_single_flit();
    do_reset();
    set_req(0, 1, 1, 1);
    @(negedge clk);
    vectors++; if (grant !== 7'b0000001) begin miscompares++; $display("FAIL single_grant: got %b want 0000001", grant); end
    vectors++; if (out_valid !== 7'b0000010) begin miscompares++; $display("FAIL single_out_valid: got %b want 0000010", out_valid); end
    vectors++; if (xbar_sel[1] !== 3'd0) begin miscompares++; $display("FAIL single_sel: got %0d want 0", xbar_sel[1]); end
    next_cycle();
    clr_in();
    // Idle again with 3 credits left: three more heads pass, the fourth stalls.
    set_req(2, 1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (grant[2] !== (k < 3)) begin
        miscompares++; $display("FAIL single_credit_left k=%0d: got %b want %0d", k, grant[2], (k < 3));
      end
      next_cycle();
    end
    clr_in();
  endtask

  task automatic test_round_robin();
    int seq[6];
    seq = '{2, 3, 5, 2, 3, 5};
    do_reset();
    set_req(2, 3, 1, 1); set_req(3, 3, 1, 1); set_req(5, 3, 1, 1);
    credit_in[3] = 1'b1;  // returned every cycle so NORTH never runs dry
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (grant !== 7'(1 << seq[k])) begin
        miscompares++; $display("FAIL rr_grant k=%0d: got %b want input %0d", k, grant, seq[k]);
      end
      vectors++;
      if (xbar_sel[3] !== 3'(seq[k])) begin
        miscompares++; $display("FAIL rr_sel k=%0d: got %0d want %0d", k, xbar_sel[3], seq[k]);
      end
      next_cycle();
    end
    clr_in();
    @(negedge clk);
    vectors++; if (credit_err !== 1'b0) begin miscompares++; $display("FAIL rr_err: got %b want 0", credit_err); end
    next_cycle();
  endtask

  task automatic test_wormhole();
    int exp_in[4];
    exp_in = '{1, 1, 1, 4};
    do_reset();
    set_req(4, 5, 1, 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) set_req(1, 5, 1, 0);
      else if (k == 1) set_req(1, 5, 0, 0);
      else if (k == 2) set_req(1, 5, 0, 1);
      else req_valid[1] = 1'b0;
      @(negedge clk);
      vectors++;
      if (grant !== 7'(1 << exp_in[k]) || out_valid !== 7'b0100000 || xbar_sel[5] !== 3'(exp_in[k])) begin
        miscompares++;
        $display("FAIL wormhole k=%0d: got grant=%b ov=%b sel=%0d want input %0d on UP",
                 k, grant, out_valid, xbar_sel[5], exp_in[k]);
      end
      next_cycle();
    end
    clr_in();
  endtask

  task automatic test_credits();
    bit exp_g[11];
    bit cin[11];
    exp_g = '{1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 0};
    cin   = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    do_reset();
    set_req(0, 2, 1, 1);
    for (int k = 0; k < 11; k++) begin
      credit_in[2] = cin[k];
      @(negedge clk);
      vectors++;
      if (grant[0] !== exp_g[k]) begin
        miscompares++; $display("FAIL credit_seq k=%0d: got %b want %b", k, grant[0], exp_g[k]);
      end
      next_cycle();
    end
    clr_in();
    @(negedge clk);
    vectors++; if (credit_err !== 1'b0) begin miscompares++; $display("FAIL credit_no_err: got %b want 0", credit_err); end
    next_cycle();
    // Credit return into a full counter
    do_reset();
    credit_in[0] = 1'b1;
    @(negedge clk);
    vectors++; if (credit_err !== 1'b0) begin miscompares++; $display("FAIL credit_err_early: got %b want 0", credit_err); end
    next_cycle();
    credit_in[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (credit_err !== 1'b1) begin miscompares++; $display("FAIL credit_err_sticky k=%0d: got %b want 1", k, credit_err); end
      next_cycle();
    end
  endtask

  task automatic test_drop();
    do_reset();
    set_req(0, DROP, 1, 1); set_req(6, DROP, 1, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (grant !== 7'b1000001 || out_valid !== '0) begin
        miscompares++; $display("FAIL drop k=%0d: got grant=%b ov=%b want 1000001/0", k, grant, out_valid);
      end
      next_cycle();
    end
    clr_in();
`ifdef SWALLOC_DROP_CNT_EN
    @(negedge clk);
    vectors++; if (drop_count !== 16'd20) begin miscompares++; $display("FAIL drop_count: got %0d want 20", drop_count); end
    next_cycle();
`endif
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    set_req(3, 4, 1, 0);
    next_cycle();
    set_req(3, 4, 0, 0);
    next_cycle();
    next_cycle();
    // SOUTH now busy with input 3 and one credit left
    #1;
    vectors++; if (grant !== 7'b0001000) begin miscompares++; $display("FAIL mid_pre: got %b want 0001000", grant); end
    rst_n = 1'b0;
    #1;
    vectors++; if (grant !== '0 || out_valid !== '0) begin
      miscompares++; $display("FAIL mid_reset: got grant=%b ov=%b want 0/0", grant, out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_in();
    set_req(5, 4, 1, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (grant !== ((k < 4) ? 7'b0100000 : 7'b0)) begin
        miscompares++; $display("FAIL mid_after k=%0d: got %b want %b", k, grant, (k < 4) ? 7'b0100000 : 7'b0);
      end
      next_cycle();
    end
    clr_in();
  endtask

  task automatic test_random();
    int p_dest[N];
    int p_len[N];
    int p_sent[N];
    do_reset();
    model_reset();
    for (int i = 0; i < N; i++) begin
      p_dest[i] = ($urandom_range(0, 4) == 0) ? DROP : int'($urandom_range(0, 3));
      p_len[i] = int'($urandom_range(1, 4)); p_sent[i] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_port[i]  = 3'(p_dest[i]);
        req_head[i]  = (p_sent[i] == 0);
        req_tail[i]  = (p_sent[i] == p_len[i] - 1);
      end
      for (int o = 0; o < N; o++)
        credit_in[o] = (m_credit[o] < CR) && ($urandom_range(0, 2) == 0);
      model_expect();
      @(negedge clk);
      vectors++; if (grant !== exp_grant) begin
        miscompares++; $display("FAIL rand_grant c=%0d: got %b want %b", c, grant, exp_grant); end
      vectors++; if (out_valid !== exp_ov) begin
        miscompares++; $display("FAIL rand_ov c=%0d: got %b want %b", c, out_valid, exp_ov); end
      vectors++; if (xbar_sel !== exp_sel) begin
        miscompares++; $display("FAIL rand_sel c=%0d: got %h want %h", c, xbar_sel, exp_sel); end
      vectors++; if (credit_err !== m_err) begin
        miscompares++; $display("FAIL rand_err c=%0d: got %b want %b", c, credit_err, m_err); end
      model_update();
      for (int i = 0; i < N; i++) begin
        if (exp_grant[i]) begin
          if (p_sent[i] == p_len[i] - 1) begin
            p_dest[i] = ($urandom_range(0, 4) == 0) ? DROP : int'($urandom_range(0, 6));
            p_len[i]  = int'($urandom_range(1, 4)); p_sent[i] = 0;
          end else p_sent[i]++;
        end
      end
      next_cycle();
    end
    clr_in();
`ifdef SWALLOC_DROP_CNT_EN
    @(negedge clk);
    vectors++; if (drop_count !== 16'(m_drops)) begin
      miscompares++; $display("FAIL rand_drop_count: got %0d want %0d", drop_count, m_drops); end
    next_cycle();
`endif
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_wormhole();
    test_credits();
    test_drop();
    test_reset_midpacket();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router switch allocator for the 3D mesh router. It takes each input port's head-of-line flit and that flit's output-port decision from the route computation unit. For each physical output it picks one input with a round-robin arbiter, holds that output for the whole wormhole packet, and enforces credit-based flow control toward the downstream buffer. Flits routed to DROP are consumed immediately. The allocator drives the crossbar selects and the input-buffer pop strobes.

## Interface
Parameters:
- NUM_PORTS, 7, number of physical ports (LOCAL, EAST, WEST, NORTH, SOUTH, UP, DOWN), indexed by `port_t` value 0..6
- CREDITS, 4, downstream input-buffer depth per output; reset value of each credit counter

Ports:
- clk  in  1  router clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  input i has a flit at head of line
- req_port  in  NUM_PORTS x `port_t`  requested output for input i; constant for all flits of a packet
- req_head  in  NUM_PORTS  flit i is a head flit
- req_tail  in  NUM_PORTS  flit i is a tail flit; a single-flit packet has head=tail=1
- grant  out  NUM_PORTS  flit i leaves this cycle; pops input buffer i
- out_valid  out  NUM_PORTS  output o carries a flit this cycle
- xbar_sel  out  NUM_PORTS x $clog2(NUM_PORTS)  input driving output o; 0 when out_valid[o]=0
- credit_in  in  NUM_PORTS  downstream of output o freed one slot
- credit_err  out  1  sticky; a credit return was seen with the counter already at CREDITS

## Operation
- Per-output state is:
  - FSM IDLE/BUSY
  - owner (3b)
  - rr_ptr (3b)
  - credit count (0..CREDITS, width $clog2(CREDITS+1))
- An output o is eligible when credit[o] > 0.
- IDLE: the candidates are inputs i with req_valid, req_head and req_port == o.
  - The winner is the first candidate at or after rr_ptr, searched cyclically modulo NUM_PORTS.
  - On a grant, rr_ptr becomes (winner+1) mod NUM_PORTS and owner becomes winner.
  - If the granted flit is not a tail, the FSM moves to BUSY.
- BUSY: only the owner can be granted, and only when req_valid[owner], req_port == o and credit > 0.
  - A non-owner head requesting o waits.
  - A granted tail returns the FSM to IDLE.
  - rr_ptr does not change while BUSY.
- Credits:
  - A grant alone decrements the counter.
  - credit_in alone increments it.
  - Both in the same cycle leave it unchanged.
  - An increment at CREDITS saturates and sets credit_err.
- DROP (req_port == DROP): the flit is granted every cycle it is valid. It uses no credit and no output, and out_valid is unaffected.
- req_port values outside LOCAL..DOWN and DROP are never granted.
- Each input receives at most one grant per cycle, because it requests exactly one output.

## Timing
- grant, out_valid and xbar_sel are combinational from the inputs and the registered state, so there is zero-cycle allocation latency.
- Flit traversal happens in the same cycle as the grant.
- All state updates on the rising edge of clk.
- A credit returned in cycle N makes the output eligible in cycle N+1. It does not make it eligible in cycle N.
- Reset (rst_n=0, asynchronous, including mid-packet):
  - every FSM goes to IDLE, owner=0, rr_ptr=0, credit=CREDITS, credit_err=0
  - grant, out_valid and xbar_sel are forced to 0 while reset is asserted
  - packets in flight are abandoned; upstream must also be reset
- A head and tail granted in the same flit (single-flit packet) leaves the FSM in IDLE.
- When all NUM_PORTS inputs request the same idle output continuously, each input wins once every NUM_PORTS packets.

## Configuration
- SWALLOC_DROP_CNT_EN, when defined:
  - adds output drop_count (out, 16)
  - drop_count increments by the number of DROP flits granted in the cycle, saturating at 16'hFFFF
  - resets to 0
- When undefined, the port and the counter are absent, and DROP behaviour is otherwise identical.

## Test plan
- Single-flit packet, input 0 to EAST(1), credit 4: grant[0]=1 and out_valid[1]=1 with xbar_sel[1]=0 in the same cycle; credit[1]=3; the FSM stays IDLE.
- Inputs 2, 3 and 5 each send single-flit heads to NORTH continuously from reset: grants go 2, 3, 5, 2, 3, 5 on consecutive cycles.
- Input 1 sends a 3-flit packet to UP while input 4 presents a head to UP in the same cycles: the 3 flits of input 1 are granted back-to-back; input 4 is granted in the cycle after input 1's tail.
- Credits: 4 consecutive grants to WEST with no credit_in, then a 5th request: no grant. Pulse credit_in[WEST]: the request is granted the next cycle. credit_in and a grant in the same cycle: the count holds.
- DROP flood: inputs 0 and 6 send DROP for 10 cycles: both are granted every cycle, out_valid=0. With SWALLOC_DROP_CNT_EN defined, drop_count=20.
- Assert rst_n=0 mid-packet while BUSY on SOUTH with credit=1: grant and out_valid go to 0 immediately. After release, credit=CREDITS and a new head from a different input is granted at once.
